riscv_load_ext: RTL and testbench
=================================

# riscv_load_ext

Parametrised load-data extraction and extension unit for the LSU response path. It accepts a load descriptor (funct3, low address bits, destination tag) and one or two memory data beats. It selects the addressed bytes, including a misaligned access that crosses a bus-word boundary, and sign- or zero-extends them to XLEN. The result is returned through a valid/ready response port toward writeback, generalising the fixed-width combinational extender to a sized, aligned, flow-controlled stage.

## Interface
- XLEN, 64: register/bus width; legal values 32 or 64 only. BUS_BYTES = XLEN/8, OFS_W = $clog2(BUS_BYTES).
- TAG_W, 5: width of the destination-register tag carried with the request.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  load descriptor valid.
- req_ready_o  out  1  descriptor accepted when valid&ready.
- req_funct3_i  in  3  RISC-V load funct3.
- req_ofs_i  in  OFS_W  byte offset of the access within the bus word.
- req_tag_i  in  TAG_W  destination tag.
- beat_valid_i  in  1  memory data beat valid.
- beat_ready_o  out  1  beat consumed when valid&ready.
- beat_data_i  in  XLEN  memory data beat, little-endian.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  writeback accepts result.
- rsp_data_o  out  XLEN  extended load result.
- rsp_tag_o  out  TAG_W  tag of the result.
- rsp_err_o  out  1  illegal funct3 for this XLEN.

## Operation
- funct3 decoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. For XLEN=64 only, 011 LD and 110 LWU are also legal. Every other code is illegal.
- Access size S is 1, 2, 4 or 8 bytes. Codes 0xx are sign-extended; codes 1xx are zero-extended. LD needs no extension.
- Crossing: ofs + S > BUS_BYTES requires two beats. The first beat supplies bytes ofs..BUS_BYTES-1. The second beat supplies the remaining bytes from its byte 0 upward.
- Extraction: take {beat2, beat1} >> (8*ofs), keep the low 8*S bits, then extend to XLEN. For a single beat, beat2 is treated as 0.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
  - IDLE: req_ready_o=1. On a descriptor handshake, register funct3, ofs and tag.
    - Legal funct3: go to BEAT1.
    - Illegal funct3: go to RESP with rsp_err_o=1, rsp_data_o=0, and no beats consumed.
  - BEAT1: beat_ready_o=1. On a beat handshake, store the beat.
    - Crossing access: go to BEAT2.
    - Otherwise: compute the result and go to RESP.
  - BEAT2: beat_ready_o=1. On a beat handshake, compute the result from both beats and go to RESP.
  - RESP: rsp_valid_o=1. On rsp_valid_o&rsp_ready_i, go to IDLE.
- Output stability: rsp_data_o, rsp_tag_o and rsp_err_o are registered and hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Ready signals: req_ready_o=0 and beat_ready_o=0 outside their own states. Beats presented in IDLE or RESP are not consumed.
- One transaction is in flight at a time; there is no descriptor/response overlap.

## Timing
- Reset values: state IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_tag_o=0, rsp_err_o=0, beat_ready_o=0, req_ready_o=1.
- Reset asserted mid-transaction aborts it immediately:
  - captured beats and descriptor are discarded;
  - no response is produced;
  - upstream must not replay beats of the aborted load.
- Latency:
  - descriptor handshake at cycle N → beat_ready_o=1 at N+1;
  - final beat handshake at cycle M → rsp_valid_o=1 at M+1;
  - illegal descriptor at N → rsp_valid_o=1 at N+1.
- Response handshake at cycle K → req_ready_o=1 at K+1. Minimum throughput is one single-beat load per 3 cycles.
- The descriptor and beat ports never handshake in the same cycle, because their ready signals are mutually exclusive.

## Test plan
- XLEN=64, LB, ofs=3, beat 0x0123456789ABCDEF → rsp_data_o=0xFFFFFFFFFFFFFF89 and rsp_err_o=0. rsp_valid_o rises exactly 1 cycle after the beat handshake.
- LHU, ofs=6, same beat → 0x0000000000000123. LH, ofs=0 → 0xFFFFFFFFFFFFCDEF.
- Crossing LW, ofs=6:
  - beat1 0x0123456789ABCDEF, beat2 0xFFEEDDCCBBAA9988;
  - two beats consumed;
  - rsp_data_o=0xFFFFFFFF99880123.
- XLEN=32, funct3=011 (and XLEN=64, funct3=111) → rsp_err_o=1, rsp_data_o=0, beat_ready_o never asserted, rsp_valid_o 1 cycle after the descriptor. Tag 0x1A is echoed.
- rsp_ready_i held low 4 cycles after the result → rsp_data_o/rsp_tag_o stable, req_ready_o=0, a presented beat is not consumed. Handshake → req_ready_o=1 on the next cycle.
- rst_ni pulsed low in BEAT2 → rsp_valid_o=0 and req_ready_o=1 immediately. A following LBU, ofs=7, beat 0x80FF... → 0x0000000000000080.

Source files
------------

// File: rtl/riscv_load_ext.sv
// Load-data extraction/extension stage: takes a load descriptor plus one or two bus beats,
// selects the addressed bytes (including word-crossing accesses) and sign/zero-extends to XLEN.
module riscv_load_ext #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5,
  localparam int unsigned OFS_W = $clog2(XLEN / 8)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [OFS_W-1:0] req_ofs_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             beat_valid_i,
  output logic             beat_ready_o,
  input  logic [XLEN-1:0]  beat_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o
);

  localparam int BUS_BYTES = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StResp} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [2:0]         r_funct3;
  logic [OFS_W-1:0]   r_ofs;
  logic [TAG_W-1:0]   r_tag;
  logic [XLEN-1:0]    r_beat1;
  logic [XLEN-1:0]    r_rsp_data;
  logic               r_rsp_err;

  logic               w_req_legal;
  logic               w_cross;
  int                 w_bytes;
  logic [2*XLEN-1:0]  w_pair;
  logic [XLEN-1:0]    w_sel;
  logic [XLEN-1:0]    w_mask;
  logic               w_msb;
  logic               w_neg;
  logic [XLEN-1:0]    w_result;

  function automatic logic f_legal(input logic [2:0] f);
    logic ok;
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      3'b011, 3'b110:                         ok = (XLEN == 64);
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_req_legal = f_legal(req_funct3_i);

  // funct3[1:0] encodes log2 of the access size for every legal code.
  assign w_bytes = 1 << r_funct3[1:0];
  assign w_cross = (int'(r_ofs) + w_bytes) > BUS_BYTES;

  // In BEAT2 the stored beat is the low half; in BEAT1 the upper half is zero.
  assign w_pair = (r_state == StBeat2) ? {beat_data_i, r_beat1} : {{XLEN{1'b0}}, beat_data_i};

  always_comb begin
    w_sel  = '0;
    w_mask = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      w_sel[8*i +: 8]  = w_pair[8*(int'(r_ofs) + i) +: 8];
      w_mask[8*i +: 8] = (i < w_bytes) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    case (r_funct3[1:0])
      2'd0:    w_msb = w_sel[7];
      2'd1:    w_msb = w_sel[15];
      2'd2:    w_msb = w_sel[31];
      default: w_msb = 1'b0;
    endcase
  end

  assign w_neg    = ~r_funct3[2] & w_msb;
  assign w_result = (w_sel & w_mask) | ({XLEN{w_neg}} & ~w_mask);

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    beat_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_next = w_req_legal ? StBeat1 : StResp;
      end
      StBeat1: begin
        beat_ready_o = 1'b1;
        if (beat_valid_i) w_state_next = w_cross ? StBeat2 : StResp;
      end
      StBeat2: begin
        beat_ready_o = 1'b1;
        if (beat_valid_i) w_state_next = StResp;
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_funct3   <= '0;
      r_ofs      <= '0;
      r_tag      <= '0;
      r_beat1    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && req_valid_i) begin
        r_funct3   <= req_funct3_i;
        r_ofs      <= req_ofs_i;
        r_tag      <= req_tag_i;
        r_rsp_err  <= ~w_req_legal;
        r_rsp_data <= '0;
      end
      if (r_state == StBeat1 && beat_valid_i) begin
        r_beat1 <= beat_data_i;
        if (!w_cross) r_rsp_data <= w_result;
      end
      if (r_state == StBeat2 && beat_valid_i) r_rsp_data <= w_result;
    end
  end

  assign rsp_data_o = r_rsp_data;
  assign rsp_tag_o  = r_tag;
  assign rsp_err_o  = r_rsp_err;

endmodule

// File: tb/tb_riscv_load_ext.sv
// Directed self-checking bench for riscv_load_ext (XLEN=64 main instance, XLEN=32 for decode).
module tb_riscv_load_ext;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [2:0]  req_ofs = '0;
  logic [4:0]  req_tag = '0;
  logic        beat_valid = 1'b0;
  logic        beat_ready;
  logic [63:0] beat_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_err;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [2:0]  s_req_funct3 = '0;
  logic [1:0]  s_req_ofs = '0;
  logic [4:0]  s_req_tag = '0;
  logic        s_beat_ready;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b0;
  logic [31:0] s_rsp_data;
  logic [4:0]  s_rsp_tag;
  logic        s_rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  riscv_load_ext #(.XLEN(64), .TAG_W(5)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
    .req_ofs_i(req_ofs), .req_tag_i(req_tag),
    .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_data_i(beat_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err)
  );

  riscv_load_ext #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_funct3_i(s_req_funct3),
    .req_ofs_i(s_req_ofs), .req_tag_i(s_req_tag),
    .beat_valid_i(1'b0), .beat_ready_o(s_beat_ready), .beat_data_i(32'h0),
    .rsp_valid_o(s_rsp_valid), .rsp_ready_i(s_rsp_ready), .rsp_data_o(s_rsp_data),
    .rsp_tag_o(s_rsp_tag), .rsp_err_o(s_rsp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rsp_valid, req_ready, beat_ready, rsp_err} !== 4'b0100)
      $display("FAIL reset_ctrl: got v/rr/br/err=%b expected 0100",
               {rsp_valid, req_ready, beat_ready, rsp_err});
    else n_pass++;
    n_checks++;
    if (rsp_data !== 64'h0 || rsp_tag !== 5'h0)
      $display("FAIL reset_data: got data=%h tag=%h expected 0/0", rsp_data, rsp_tag);
    else n_pass++;
  endtask

  // One single-beat load; exactly three clock edges, so repeated calls run back to back.
  task automatic test_single(input string name, input logic [2:0] f3, input logic [2:0] ofs,
                             input logic [4:0] tag, input logic [63:0] beat,
                             input logic [63:0] exp);
    req_valid = 1'b1; req_funct3 = f3; req_ofs = ofs; req_tag = tag;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
    else n_pass++;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (beat_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL %s beat_phase: got br=%b v=%b expected 1/0", name, beat_ready, rsp_valid);
    else n_pass++;
    beat_valid = 1'b1; beat_data = beat;
    step();
    beat_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || beat_ready !== 1'b0)
      $display("FAIL %s rsp_latency: got v=%b br=%b expected 1/0", name, rsp_valid, beat_ready);
    else n_pass++;
    n_checks++;
    if (rsp_data !== exp || rsp_err !== 1'b0 || rsp_tag !== tag)
      $display("FAIL %s result: got %h err=%b tag=%h expected %h err=0 tag=%h",
               name, rsp_data, rsp_err, rsp_tag, exp, tag);
    else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL %s release: got rr=%b v=%b expected 1/0", name, req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_cross();
    req_valid = 1'b1; req_funct3 = 3'b010; req_ofs = 3'd6; req_tag = 5'h07;
    step();
    req_valid = 1'b0;
    beat_valid = 1'b1; beat_data = 64'h0123456789ABCDEF;
    step();
    n_checks++;
    if (beat_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL cross_second_beat: got br=%b v=%b expected 1/0", beat_ready, rsp_valid);
    else n_pass++;
    beat_data = 64'hFFEEDDCCBBAA9988;
    step();
    beat_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFFFFFF99880123)
      $display("FAIL cross_result: got v=%b %h expected 1 ffffffff99880123", rsp_valid, rsp_data);
    else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; req_funct3 = 3'b111; req_ofs = 3'd0; req_tag = 5'h1A;
    beat_valid = 1'b1; beat_data = 64'hDEADBEEFDEADBEEF;
    s_req_valid = 1'b1; s_req_funct3 = 3'b011; s_req_ofs = 2'd0; s_req_tag = 5'h1A;
    step();
    req_valid = 1'b0; s_req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 64'h0 || rsp_tag !== 5'h1A)
      $display("FAIL illegal64: got v=%b err=%b data=%h tag=%h expected 1/1/0/1a",
               rsp_valid, rsp_err, rsp_data, rsp_tag);
    else n_pass++;
    n_checks++;
    if (beat_ready !== 1'b0 || s_beat_ready !== 1'b0)
      $display("FAIL illegal_beat_ready: got %b/%b expected 0/0", beat_ready, s_beat_ready);
    else n_pass++;
    n_checks++;
    if (s_rsp_valid !== 1'b1 || s_rsp_err !== 1'b1 || s_rsp_data !== 32'h0 || s_rsp_tag !== 5'h1A)
      $display("FAIL illegal32_ld: got v=%b err=%b data=%h tag=%h expected 1/1/0/1a",
               s_rsp_valid, s_rsp_err, s_rsp_data, s_rsp_tag);
    else n_pass++;
    beat_valid = 1'b0;
    rsp_ready = 1'b1; s_rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; s_rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || s_req_ready !== 1'b1)
      $display("FAIL illegal_release: got %b/%b expected 1/1", req_ready, s_req_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    req_valid = 1'b1; req_funct3 = 3'b000; req_ofs = 3'd3; req_tag = 5'h0C;
    step();
    req_valid = 1'b0;
    beat_valid = 1'b1; beat_data = 64'h0123456789ABCDEF;
    step();
    beat_data = 64'h5555AAAA5555AAAA;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 64'hFFFFFFFFFFFFFF89 || rsp_tag !== 5'h0C ||
          req_ready !== 1'b0 || beat_ready !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL backpressure_hold: got %0d bad cycles expected 0 (data=%h tag=%h)",
               bad, rsp_data, rsp_tag);
    else n_pass++;
    beat_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL backpressure_release: got rr=%b v=%b expected 1/0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1; req_funct3 = 3'b010; req_ofs = 3'd6; req_tag = 5'h03;
    step();
    req_valid = 1'b0;
    beat_valid = 1'b1; beat_data = 64'h0123456789ABCDEF;
    step();
    beat_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || beat_ready !== 1'b0)
      $display("FAIL abort_immediate: got v=%b rr=%b br=%b expected 0/1/0",
               rsp_valid, req_ready, beat_ready);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 64'h0)
      $display("FAIL abort_no_rsp: got v=%b data=%h expected 0/0", rsp_valid, rsp_data);
    else n_pass++;
    test_single("abort_lbu", 3'b100, 3'd7, 5'h11, 64'h80FFFFFFFFFFFFFF, 64'h0000000000000080);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_single("lb_ofs3", 3'b000, 3'd3, 5'h01, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFF89);
    test_single("lhu_ofs6", 3'b101, 3'd6, 5'h02, 64'h0123456789ABCDEF, 64'h0000000000000123);
    test_single("lh_ofs0", 3'b001, 3'd0, 5'h03, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFCDEF);
    test_single("lwu_ofs4", 3'b110, 3'd4, 5'h04, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF);
    test_single("ld_ofs0", 3'b011, 3'd0, 5'h05, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    test_cross();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
